// File: rtl/display_control.sv
// Control FSM and counters for the note-display datapath: grid clear, beat
// timing, shifting the song, and a pixel-by-pixel redraw of three note boxes.
module display_control #(
  parameter int unsigned GRID_W      = 240,
  parameter int unsigned GRID_H      = 120,
  parameter int unsigned BOX_W       = 60,
  parameter int unsigned BOX_H       = 20,
  parameter int unsigned BEAT_CYCLES = 7204,
  parameter int unsigned SONG_BEATS  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  output logic        shiftSong,
  output logic        loadStartAddress,
  output logic        loadX,
  output logic        loadY,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        writeToScreen,
  output logic        songDone,
  output logic [15:0] gridCounter,
  output logic [1:0]  boxCounter,
  output logic [15:0] pixelCount
);

  localparam int unsigned TW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int unsigned BW = $clog2(SONG_BEATS + 1);

  localparam logic [7:0]    GX_LAST    = 8'(GRID_W - 1);
  localparam logic [6:0]    GY_LAST    = 7'(GRID_H - 1);
  localparam logic [7:0]    BX_LAST    = 8'(BOX_W - 1);
  localparam logic [6:0]    BY_LAST    = 7'(BOX_H - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BEAT_CYCLES - 1);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(SONG_BEATS);

  typedef enum logic [3:0] {
    CLR_LOAD,
    CLR_WRITE,
    IDLE,
    WAIT_BEAT,
    SHIFT,
    BOX_SETUP,
    BOX_LOAD,
    BOX_WRITE,
    CHECK,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          init_q, init_d;
  logic [7:0]    gx_q, gx_d;
  logic [6:0]    gy_q, gy_d;
  logic [7:0]    px_q, px_d;
  logic [6:0]    py_q, py_d;
  logic [1:0]    box_q, box_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] timer_q, timer_d;

  logic shift_song_q, shift_song_d;
  logic load_start_q, load_start_d;
  logic load_xy_q, load_xy_d;
  logic load_default_q, load_default_d;
  logic write_default_q, write_default_d;
  logic write_screen_q, write_screen_d;
  logic song_done_q, song_done_d;

  always_comb begin
    state_d = state_q;
    init_d  = 1'b0;
    gx_d    = gx_q;
    gy_d    = gy_q;
    px_d    = px_q;
    py_d    = py_q;
    box_d   = box_q;
    beat_d  = beat_q;
    timer_d = timer_q;

    unique case (state_q)
      CLR_LOAD: state_d = CLR_WRITE;
      CLR_WRITE: begin
        if (gx_q == GX_LAST && gy_q == GY_LAST) begin
          gx_d    = '0;
          gy_d    = '0;
          state_d = IDLE;
        end else begin
          if (gy_q == GY_LAST) begin
            gy_d = '0;
            gx_d = gx_q + 8'd1;
          end else begin
            gy_d = gy_q + 7'd1;
          end
          state_d = CLR_LOAD;
        end
      end
      IDLE: begin
        if (go) begin
          timer_d = '0;
          state_d = WAIT_BEAT;
        end
      end
      WAIT_BEAT: begin
        if (go) begin
          if (timer_q == TIMER_LAST) begin
            state_d = SHIFT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      SHIFT: begin
        box_d   = '0;
        px_d    = '0;
        py_d    = '0;
        state_d = BOX_SETUP;
      end
      BOX_SETUP: state_d = BOX_LOAD;
      BOX_LOAD:  state_d = BOX_WRITE;
      BOX_WRITE: begin
        if (!(px_q == BX_LAST && py_q == BY_LAST)) begin
          if (py_q == BY_LAST) begin
            py_d = '0;
            px_d = px_q + 8'd1;
          end else begin
            py_d = py_q + 7'd1;
          end
          state_d = BOX_LOAD;
        end else if (box_q < 2'd2) begin
          box_d   = box_q + 2'd1;
          px_d    = '0;
          py_d    = '0;
          state_d = BOX_SETUP;
        end else begin
          box_d   = 2'd3;
          beat_d  = beat_q + BW'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (beat_q == BEAT_LAST) begin
          state_d = DONE;
        end else begin
          timer_d = '0;
          state_d = WAIT_BEAT;
        end
      end
      DONE: begin
        beat_d  = '0;
        state_d = CLR_LOAD;
      end
      default: state_d = CLR_LOAD;
    endcase

    // First edge after reset release stays in CLR_LOAD so its strobe is emitted.
    if (init_q) begin
      state_d = CLR_LOAD;
    end

    shift_song_d    = (state_d == SHIFT);
    load_start_d    = (state_d == BOX_SETUP);
    load_xy_d       = (state_d == BOX_LOAD);
    load_default_d  = (state_d == CLR_LOAD);
    write_default_d = (state_d == CLR_WRITE);
    write_screen_d  = (state_d == CLR_WRITE) || (state_d == BOX_WRITE);
    song_done_d     = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= CLR_LOAD;
      init_q          <= 1'b1;
      gx_q            <= '0;
      gy_q            <= '0;
      px_q            <= '0;
      py_q            <= '0;
      box_q           <= 2'd3;
      beat_q          <= '0;
      timer_q         <= '0;
      shift_song_q    <= 1'b0;
      load_start_q    <= 1'b0;
      load_xy_q       <= 1'b0;
      load_default_q  <= 1'b0;
      write_default_q <= 1'b0;
      write_screen_q  <= 1'b0;
      song_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_q          <= init_d;
      gx_q            <= gx_d;
      gy_q            <= gy_d;
      px_q            <= px_d;
      py_q            <= py_d;
      box_q           <= box_d;
      beat_q          <= beat_d;
      timer_q         <= timer_d;
      shift_song_q    <= shift_song_d;
      load_start_q    <= load_start_d;
      load_xy_q       <= load_xy_d;
      load_default_q  <= load_default_d;
      write_default_q <= write_default_d;
      write_screen_q  <= write_screen_d;
      song_done_q     <= song_done_d;
    end
  end

  assign shiftSong        = shift_song_q;
  assign loadStartAddress = load_start_q;
  assign loadX            = load_xy_q;
  assign loadY            = load_xy_q;
  assign loadDefault      = load_default_q;
  assign writeDefault     = write_default_q;
  assign writeToScreen    = write_screen_q;
  assign songDone         = song_done_q;
  assign gridCounter      = {1'b0, gx_q, gy_q};
  assign boxCounter       = box_q;
  assign pixelCount       = {1'b0, px_q, py_q};

endmodule

// File: tb/tb_display_control.sv
// Directed, table-driven bench for display_control on a small 4x2 grid with
// 2x2 boxes, 5-cycle beats and a 2-beat song.
module tb_display_control;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go    = 1'b0;
  logic        shiftSong, loadStartAddress, loadX, loadY;
  logic        loadDefault, writeDefault, writeToScreen, songDone;
  logic [15:0] gridCounter, pixelCount;
  logic [1:0]  boxCounter;
  logic [7:0]  strobes;

  int errors = 0;
  int checks = 0;

  display_control #(
    .GRID_W(4), .GRID_H(2), .BOX_W(2), .BOX_H(2),
    .BEAT_CYCLES(5), .SONG_BEATS(2)
  ) dut (
    .clock(clock), .reset(reset), .go(go),
    .shiftSong(shiftSong), .loadStartAddress(loadStartAddress),
    .loadX(loadX), .loadY(loadY), .loadDefault(loadDefault),
    .writeDefault(writeDefault), .writeToScreen(writeToScreen),
    .songDone(songDone), .gridCounter(gridCounter),
    .boxCounter(boxCounter), .pixelCount(pixelCount)
  );

  always #5 clock = ~clock;

  assign strobes = {shiftSong, loadStartAddress, loadX, loadY,
                    loadDefault, writeDefault, writeToScreen, songDone};

  localparam logic [7:0] S_0  = 8'b0000_0000;
  localparam logic [7:0] S_SH = 8'b1000_0000;
  localparam logic [7:0] S_SA = 8'b0100_0000;
  localparam logic [7:0] S_XY = 8'b0011_0000;
  localparam logic [7:0] S_LD = 8'b0000_1000;
  localparam logic [7:0] S_CW = 8'b0000_0110;
  localparam logic [7:0] S_BW = 8'b0000_0010;
  localparam logic [7:0] S_DN = 8'b0000_0001;

  typedef struct {
    logic        go;
    logic [7:0]  st;
    logic [15:0] gc;
    logic [1:0]  bc;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[$];

  logic [15:0] grid_seq [8] = '{16'h0000, 16'h0001, 16'h0080, 16'h0081,
                                16'h0100, 16'h0101, 16'h0180, 16'h0181};
  logic [15:0] pix_seq  [4] = '{16'h0000, 16'h0001, 16'h0080, 16'h0081};

  task automatic push(input logic g, input logic [7:0] st, input logic [15:0] gc,
                      input logic [1:0] bc, input logic [15:0] pc);
    vec_t v;
    v.go = g; v.st = st; v.gc = gc; v.bc = bc; v.pc = pc;
    tbl.push_back(v);
  endtask

  task automatic push_clear(input logic [15:0] pc);
    for (int k = 0; k < 8; k++) begin
      push(1'b0, S_LD, grid_seq[k], 2'd3, pc);
      push(1'b0, S_CW, grid_seq[k], 2'd3, pc);
    end
  endtask

  task automatic push_box(input logic g, input logic [1:0] b);
    push(g, S_SA, 16'h0000, b, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      push(g, S_XY, 16'h0000, b, pix_seq[k]);
      push(g, S_BW, 16'h0000, b, pix_seq[k]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle-by-cycle invariants on the strobes and counters.
  always @(negedge clock) begin
    checks++;
    if ((writeToScreen && (loadDefault || loadX || loadStartAddress)) ||
        (shiftSong && songDone) || (loadX !== loadY) ||
        gridCounter[15] || pixelCount[15]) begin
      errors++;
      $display("FAIL invariant at %0t: strobes=%b gc=%h pc=%h", $time, strobes,
               gridCounter, pixelCount);
    end
  end

  initial begin
    bit found;

    // Build the expected trace starting from the first edge after reset release.
    push_clear(16'h0000);
    push(1'b0, S_0, 16'h0000, 2'd3, 16'h0000);               // IDLE
    repeat (5) push(1'b1, S_0, 16'h0000, 2'd3, 16'h0000);    // WAIT_BEAT t=0..4
    push(1'b1, S_SH, 16'h0000, 2'd3, 16'h0000);              // SHIFT
    push_box(1'b1, 2'd0);
    push_box(1'b1, 2'd1);
    push_box(1'b1, 2'd2);
    push(1'b1, S_0, 16'h0000, 2'd3, 16'h0081);               // CHECK
    repeat (3) push(1'b1, S_0, 16'h0000, 2'd3, 16'h0081);    // WAIT t=0..2
    repeat (10) push(1'b0, S_0, 16'h0000, 2'd3, 16'h0081);   // paused at t=2
    repeat (2) push(1'b1, S_0, 16'h0000, 2'd3, 16'h0081);    // t=3,4
    push(1'b1, S_SH, 16'h0000, 2'd3, 16'h0081);              // SHIFT
    push_box(1'b1, 2'd0);
    push_box(1'b0, 2'd1);                                    // go dropped mid-draw
    push_box(1'b1, 2'd2);
    push(1'b1, S_0, 16'h0000, 2'd3, 16'h0081);               // CHECK
    push(1'b0, S_DN, 16'h0000, 2'd3, 16'h0081);              // DONE
    push_clear(16'h0081);
    push(1'b0, S_0, 16'h0000, 2'd3, 16'h0081);               // IDLE

    repeat (3) tick();
    chk("reset strobes", {24'd0, strobes}, {24'd0, S_0});
    chk("reset gridCounter", {16'd0, gridCounter}, 32'h0);
    chk("reset pixelCount", {16'd0, pixelCount}, 32'h0);
    chk("reset boxCounter", {30'd0, boxCounter}, 32'd3);

    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      go = tbl[i].go;
      tick();
      chk($sformatf("v%0d strobes", i), {24'd0, strobes}, {24'd0, tbl[i].st});
      chk($sformatf("v%0d gridCounter", i), {16'd0, gridCounter}, {16'd0, tbl[i].gc});
      chk($sformatf("v%0d boxCounter", i), {30'd0, boxCounter}, {30'd0, tbl[i].bc});
      chk($sformatf("v%0d pixelCount", i), {16'd0, pixelCount}, {16'd0, tbl[i].pc});
    end

    // Asynchronous reset in the middle of box 1's write.
    go = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (boxCounter == 2'd1 && writeToScreen) found = 1'b1;
    end
    chk("reach box1 write", {31'd0, found}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midreset strobes", {24'd0, strobes}, {24'd0, S_0});
    chk("midreset boxCounter", {30'd0, boxCounter}, 32'd3);
    chk("midreset pixelCount", {16'd0, pixelCount}, 32'h0);
    chk("midreset gridCounter", {16'd0, gridCounter}, 32'h0);
    go = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("restart ld%0d", k), {24'd0, strobes}, {24'd0, S_LD});
      chk($sformatf("restart ld%0d gc", k), {16'd0, gridCounter}, {16'd0, grid_seq[k]});
      tick();
      chk($sformatf("restart wr%0d", k), {24'd0, strobes}, {24'd0, S_CW});
      chk($sformatf("restart wr%0d gc", k), {16'd0, gridCounter}, {16'd0, grid_seq[k]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
